pal_macrocell_array: RTL and testbench

Parametrised successor to the combinational PAL core. Fully synchronous config chain loaded bit-serially under a small load FSM. Per-output macrocells select combinational or registered output, with optional inversion. Registered outputs feed back into the AND plane, so the array implements counters and state machines. Sits behind the TT top wrapper: config/enable on uio, data on ui/uo.

---
 rtl/pal_macrocell_array.sv | 116 +++++++++++
 tb/tb_pal_macrocell_array.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pal_macrocell_array.sv
// Registered PAL: serial config chain, AND/OR planes, macrocells with feedback.
// Optional macro CFG_READBACK_EN streams prior chain contents out on cfg_out.
module pal_macrocell_array #(
  parameter int unsigned NUM_INPUTS  = 8,
  parameter int unsigned NUM_TERMS   = 11,
  parameter int unsigned NUM_OUTPUTS = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  output logic                   cfg_done,
  output logic                   cfg_err,
  input  logic                   ena,
  input  logic [NUM_INPUTS-1:0]  in,
  output logic [NUM_OUTPUTS-1:0] out,
  output logic                   cfg_out
);

  localparam int unsigned NL      = NUM_INPUTS + NUM_OUTPUTS;
  localparam int unsigned OR_BASE = 2 * NL * NUM_TERMS;
  localparam int unsigned MC_BASE = OR_BASE + NUM_TERMS * NUM_OUTPUTS;
  localparam int unsigned LEN     = MC_BASE + 2 * NUM_OUTPUTS;
  localparam int unsigned CW      = $clog2(LEN + 1);

  typedef enum logic [1:0] {UNCONF, LOADING, CONFIGURED} state_t;

  state_t                 state, state_nx;
  logic [LEN-1:0]         chain;
  logic [CW-1:0]          count;
  logic [NUM_OUTPUTS-1:0] q;
  logic                   err_q;
  logic                   shift_c, last_c, run_c;
  logic [NL-1:0]          lits;
  logic [NUM_TERMS-1:0]   terms;
  logic [NUM_OUTPUTS-1:0] sums;

  assign shift_c  = (state == LOADING) && cfg_valid && !cfg_start;
  assign last_c   = shift_c && (count == CW'(LEN - 1));
  assign run_c    = (state == CONFIGURED) && ena;
  assign cfg_done = (state == CONFIGURED);
  assign cfg_err  = err_q;

  // Load FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= UNCONF;
    else     state <= state_nx;
  end

  // Start wins over everything; the last accepted bit completes the load
  always_comb begin
    state_nx = state;
    if (cfg_start)   state_nx = LOADING;
    else if (last_c) state_nx = CONFIGURED;
  end

  // Config chain shifts toward index 0, new bits enter at the top
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      count <= '0;
    end else if (cfg_start) begin
      count <= '0;
    end else if (shift_c) begin
      chain <= {cfg_bit, chain[LEN-1:1]};
      count <= count + CW'(1);
    end
  end

  // Sticky overrun: a shift strobe after the array is fully configured
  always_ff @(posedge clk) begin
    if (rst || cfg_start)                          err_q <= 1'b0;
    else if ((state == CONFIGURED) && cfg_valid)   err_q <= 1'b1;
  end

  // Macrocell flops always track the sum while running, whatever reg_sel says
  always_ff @(posedge clk) begin
    if (rst || cfg_start) q <= '0;
    else if (run_c)       q <= sums;
  end

  assign lits = {q, in};

  for (genvar t = 0; t < NUM_TERMS; t++) begin : g_term
    logic [NL-1:0] pos, neg;
    for (genvar j = 0; j < NL; j++) begin : g_lit
      assign pos[j] = chain[t*2*NL + 2*j];
      assign neg[j] = chain[t*2*NL + 2*j + 1];
    end
    // An empty term reads as 0 rather than the AND identity
    assign terms[t] = (|(pos | neg)) & (&((~pos | lits) & (~neg | ~lits)));
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_mc
    logic reg_sel, inv;
    assign sums[o] = |(terms & chain[OR_BASE + o*NUM_TERMS +: NUM_TERMS]);
    assign reg_sel = chain[MC_BASE + 2*o];
    assign inv     = chain[MC_BASE + 2*o + 1];
    assign out[o]  = run_c & ((reg_sel ? q[o] : sums[o]) ^ inv);
  end

`ifdef CFG_READBACK_EN
  logic rb_q;

  // Bit leaving the bottom of the chain on each accepted shift
  always_ff @(posedge clk) begin
    if (rst)          rb_q <= 1'b0;
    else if (shift_c) rb_q <= chain[0];
  end
  assign cfg_out = rb_q;
`else
  assign cfg_out = 1'b0;
`endif

endmodule

// File: tb/tb_pal_macrocell_array.sv
// Scoreboard bench for pal_macrocell_array: random stimulus vs a queue-based reference model.
module tb_pal_macrocell_array;

  localparam int NI  = 8;
  localparam int NT  = 11;
  localparam int NO  = 6;
  localparam int NL  = NI + NO;
  localparam int A   = 2 * NL * NT;
  localparam int M   = A + NT * NO;
  localparam int LEN = M + 2 * NO;
`ifdef CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, cfg_start, cfg_valid, cfg_bit, ena;
  logic [NI-1:0] in_v;
  logic          cfg_done, cfg_err, cfg_out;
  logic [NO-1:0] out_v;

  pal_macrocell_array #(.NUM_INPUTS(NI), .NUM_TERMS(NT), .NUM_OUTPUTS(NO)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .ena(ena), .in(in_v), .out(out_v), .cfg_out(cfg_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NO-1:0] out;
    logic          done, err, cout;
    logic [NO-1:0] fmask, fval;
    logic          cmask, cval;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: chain as a FIFO of bits, element 0 is chain index 0
  bit            m_chain[$];
  int            m_count = 0;
  bit            m_loading = 0, m_done = 0, m_err = 0, m_cout = 0;
  logic [NO-1:0] m_q = '0;
  logic          pend_cm = 1'b0, pend_cv = 1'b0;
  logic [LEN-1:0] cfg_w, cfg_a, cfg_b, cfg_c;

  function automatic logic [NO-1:0] model_sums();
    logic [NL-1:0] lit;
    logic [NO-1:0] s;
    lit = {m_q, in_v};
    s = '0;
    for (int t = 0; t < NT; t++) begin
      bit any, val;
      any = 0; val = 1;
      for (int j = 0; j < NL; j++) begin
        if (m_chain[t*2*NL + 2*j])     begin any = 1; if (!lit[j]) val = 0; end
        if (m_chain[t*2*NL + 2*j + 1]) begin any = 1; if (lit[j])  val = 0; end
      end
      for (int o = 0; o < NO; o++)
        if (any && val && m_chain[A + o*NT + t]) s[o] = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [NO-1:0] model_out();
    logic [NO-1:0] s, r;
    s = model_sums();
    r = '0;
    for (int o = 0; o < NO; o++) begin
      logic v;
      v = m_chain[M + 2*o] ? m_q[o] : s[o];
      if (m_done && ena) r[o] = v ^ m_chain[M + 2*o + 1];
    end
    return r;
  endfunction

  function automatic void model_edge();
    logic [NO-1:0] s;
    bit was_done;
    s = model_sums();
    was_done = m_done;
    if (rst) begin
      m_chain = {};
      for (int i = 0; i < LEN; i++) m_chain.push_back(1'b0);
      m_count = 0; m_loading = 0; m_done = 0; m_err = 0; m_q = '0; m_cout = 0;
    end else if (cfg_start) begin
      m_loading = 1; m_done = 0; m_count = 0; m_err = 0; m_q = '0;
    end else begin
      if (was_done && ena) m_q = s;
      if (cfg_valid && m_loading) begin
        bit b;
        b = m_chain.pop_front();
        if (RB) m_cout = b;
        m_chain.push_back(cfg_bit);
        m_count++;
        if (m_count == LEN) begin m_loading = 0; m_done = 1; end
      end else if (cfg_valid && was_done) begin
        m_err = 1;
      end
    end
  endfunction

  task automatic tick_chk(input logic [NO-1:0] fm, input logic [NO-1:0] fv, input string nm);
    exp_t e;
    e.out = model_out(); e.done = m_done; e.err = m_err; e.cout = m_cout;
    e.fmask = fm; e.fval = fv; e.cmask = pend_cm; e.cval = pend_cv; e.name = nm;
    pend_cm = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    tick_chk('0, '0, "cyc");
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".out"},  8'(out_v),    8'(e.out));
        chk({e.name, ".done"}, 8'(cfg_done), 8'(e.done));
        chk({e.name, ".err"},  8'(cfg_err),  8'(e.err));
        chk({e.name, ".cout"}, 8'(cfg_out),  8'(e.cout));
        if (e.fmask != '0) chk({e.name, ".fixed"}, 8'(out_v & e.fmask), 8'(e.fval));
        if (e.cmask)       chk({e.name, ".readback"}, 8'(cfg_out), 8'(e.cval));
      end
    end
  end

  function automatic void and_lit(input int t, input int j, input bit neg);
    cfg_w[t*2*NL + 2*j + int'(neg)] = 1'b1;
  endfunction

  function automatic void or_conn(input int o, input int t);
    cfg_w[A + o*NT + t] = 1'b1;
  endfunction

  // Fixed O0..O2 functions plus random terms 3..10 feeding O3..O5
  function automatic void build(input bit o2_reg);
    cfg_w = '0;
    and_lit(0, 0, 1); or_conn(0, 0);
    and_lit(1, 1, 0); and_lit(1, 2, 0); or_conn(0, 1);
    and_lit(2, NI + 1, 1); or_conn(1, 2);
    cfg_w[M + 2*1] = 1'b1;
    cfg_w[M + 2*2] = o2_reg;
    cfg_w[M + 2*2 + 1] = 1'b1;
    for (int t = 3; t < NT; t++) begin
      for (int j = 0; j < NL; j++) begin
        int r;
        r = int'($urandom_range(5));
        if (r == 0) and_lit(t, j, 0);
        else if (r == 1) and_lit(t, j, 1);
      end
      for (int o = 3; o < NO; o++) if ($urandom_range(2) == 0) or_conn(o, t);
    end
    for (int o = 3; o < NO; o++) begin
      cfg_w[M + 2*o]     = 1'($urandom);
      cfg_w[M + 2*o + 1] = 1'($urandom);
    end
  endfunction

  task automatic load(input logic [LEN-1:0] p, input int n, input bit rb_chk, input logic [LEN-1:0] rb);
    cfg_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(7) == 0) begin
        cfg_valid = 1'b0; cfg_bit = 1'($urandom); in_v = NI'($urandom);
        tick();
      end
      cfg_valid = 1'b1; cfg_bit = p[i]; in_v = NI'($urandom); ena = 1'($urandom);
      tick_chk('1, '0, "loading");
      if (rb_chk) begin pend_cm = 1'b1; pend_cv = RB ? rb[i] : 1'b0; end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      in_v = NI'($urandom);
      ena  = ($urandom_range(3) != 0);
      tick();
    end
  endtask

  initial begin
    logic [7:0] pats[5];
    logic [4:0] o0_exp;
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; ena = 1'b0; in_v = '0;
    for (int i = 0; i < LEN; i++) m_chain.push_back(1'b0);
    @(posedge clk); #1;
    tick(); tick();
    rst = 1'b0;

    // Unconfigured: strobes ignored, outputs stay low
    ena = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_v = NI'($urandom); cfg_valid = 1'($urandom); cfg_bit = 1'($urandom);
      tick_chk('1, '0, "unconf");
    end
    cfg_valid = 1'b0;

    build(1'b0); cfg_a = cfg_w;
    build(1'b1); cfg_b = cfg_w;
    build(1'b0); cfg_c = cfg_w;

    cfg_start = 1'b1; tick();
    load(cfg_a, LEN, 1'b0, '0);

    // O0 = ~I0 | (I1 & I2), O2 constant 1
    ena = 1'b1;
    pats[0] = 8'h00; pats[1] = 8'h06; pats[2] = 8'h01; pats[3] = 8'h03; pats[4] = 8'h07;
    o0_exp = 5'b10011;
    for (int i = 0; i < 5; i++) begin
      in_v = pats[i];
      tick_chk(6'b000101, {3'b000, 1'b1, 1'b0, o0_exp[i]}, "o0_comb");
    end
    run_random(60);

    // Toggle on O1, then freeze with ena low
    ena = 1'b1; in_v = '0;
    repeat (4) tick();
    ena = 1'b0;
    repeat (3) tick_chk('1, '0, "ena_off");
    ena = 1'b1;
    repeat (4) tick();

    // Overrun after done, then restart clears flags
    cfg_valid = 1'b1; cfg_bit = 1'($urandom); tick();
    cfg_valid = 1'b0; tick(); tick();
    cfg_start = 1'b1; tick();
    cfg_start = 1'b0; tick_chk('1, '0, "after_start");

    // Abort mid-load at bit 100, then a full load is required
    load(cfg_b, 100, 1'b0, '0);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1; tick();
    load(cfg_b, LEN, 1'b0, '0);
    ena = 1'b0; tick_chk('1, '0, "o2_reg_off");
    ena = 1'b1; in_v = NI'($urandom);
    tick_chk(6'b000100, 6'b000100, "o2_reg_on");
    tick_chk(6'b000100, 6'b000100, "o2_reg_hold");
    run_random(50);

    // Second full load streams the previous bitstream out in order
    cfg_start = 1'b1; tick();
    load(cfg_c, LEN, 1'b1, cfg_b);
    run_random(30);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
